// File: rtl/multcyc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/mem/wb
// and drives datapath selects and strobes from the current state.
module multcyc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       mem_addr_sel,
  output logic       alu_srca_sel,
  output logic [1:0] alu_srcb_sel,
  output logic [1:0] alu_op,
  output logic       wreg_dst_sel,
  output logic       wrbck_data_sel,
  output logic [1:0] nxt_pc_sel,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       pc_wr_cond,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic       reg_wr,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    MEM_ADDR   = 4'd2,
    MEM_RD     = 4'd3,
    MEM_WRBCK  = 4'd4,
    MEM_WR     = 4'd5,
    RR_EXEC    = 4'd6,
    ALU_RR_WB  = 4'd7,
    BEQ_ST     = 4'd8,
    JMP        = 4'd9,
    ADDI_EXEC  = 4'd10,
    ADDIU_EXEC = 4'd11,
    ALU_RI_WB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RR    = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_RS     = 1'b1;
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BEQIMM = 2'd3;
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_RR    = 2'd2;
  localparam logic [1:0] ALUOP_ADDU  = 2'd3;
  localparam logic       WR_RT       = 1'b0;
  localparam logic       WR_RD       = 1'b1;
  localparam logic       WB_ALUOUT   = 1'b0;
  localparam logic       WB_MEMDATA  = 1'b1;
  localparam logic [1:0] PC_PLUS4    = 2'd0;
  localparam logic [1:0] PC_BRANCH   = 2'd1;
  localparam logic [1:0] PC_JMP      = 2'd2;

  state_t state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      unique case (state_q)
        FETCH:     if (mem_ready) state_q <= DECODE;
        DECODE: begin
          unique case (opcode)
            OP_RR:           state_q <= RR_EXEC;
            OP_LW, OP_SW:    state_q <= MEM_ADDR;
            OP_BEQ:          state_q <= BEQ_ST;
            OP_J:            state_q <= JMP;
            OP_ADDI:         state_q <= ADDI_EXEC;
            OP_ADDIU:        state_q <= ADDIU_EXEC;
            default:         state_q <= FETCH;
          endcase
        end
        MEM_ADDR:  state_q <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:    if (mem_ready) state_q <= MEM_WRBCK;
        MEM_WR:    if (mem_ready) state_q <= FETCH;
        RR_EXEC:   state_q <= ALU_RR_WB;
        ADDI_EXEC: state_q <= ALU_RI_WB;
        ADDIU_EXEC: state_q <= ALU_RI_WB;
        default:   state_q <= FETCH;
      endcase
    end
  end

  assign state = state_q;

  // Outputs are held at their idle values while reset is asserted.
  always_comb begin
    mem_addr_sel   = ADDR_PC;
    alu_srca_sel   = SRCA_PC;
    alu_srcb_sel   = SRCB_RT;
    alu_op         = ALUOP_ADD;
    wreg_dst_sel   = WR_RT;
    wrbck_data_sel = WB_ALUOUT;
    nxt_pc_sel     = PC_PLUS4;
    ir_wr          = 1'b0;
    pc_wr          = 1'b0;
    pc_wr_cond     = 1'b0;
    mem_wr         = 1'b0;
    mem_rd         = 1'b0;
    reg_wr         = 1'b0;
    instr_done     = 1'b0;
    illegal_op     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          mem_rd       = 1'b1;
          alu_srcb_sel = SRCB_FOUR;
          ir_wr        = mem_ready;
          pc_wr        = mem_ready;
        end
        DECODE: begin
          alu_srcb_sel = SRCB_BEQIMM;
          unique case (opcode)
            OP_RR, OP_LW, OP_SW, OP_BEQ,
            OP_J, OP_ADDI, OP_ADDIU: illegal_op = 1'b0;
            default:                 illegal_op = 1'b1;
          endcase
        end
        MEM_ADDR: begin
          alu_srca_sel = SRCA_RS;
          alu_srcb_sel = SRCB_IMM;
        end
        MEM_RD: begin
          mem_addr_sel = ADDR_ALUOUT;
          mem_rd       = 1'b1;
        end
        MEM_WRBCK: begin
          reg_wr         = 1'b1;
          wrbck_data_sel = WB_MEMDATA;
          instr_done     = 1'b1;
        end
        MEM_WR: begin
          mem_addr_sel = ADDR_ALUOUT;
          mem_wr       = 1'b1;
          instr_done   = mem_ready;
        end
        RR_EXEC: begin
          alu_srca_sel = SRCA_RS;
          alu_op       = ALUOP_RR;
        end
        ALU_RR_WB: begin
          reg_wr       = 1'b1;
          wreg_dst_sel = WR_RD;
          instr_done   = 1'b1;
        end
        BEQ_ST: begin
          alu_srca_sel = SRCA_RS;
          alu_op       = ALUOP_SUB;
          pc_wr_cond   = 1'b1;
          nxt_pc_sel   = PC_BRANCH;
          instr_done   = 1'b1;
        end
        JMP: begin
          pc_wr      = 1'b1;
          nxt_pc_sel = PC_JMP;
          instr_done = 1'b1;
        end
        ADDI_EXEC: begin
          alu_srca_sel = SRCA_RS;
          alu_srcb_sel = SRCB_IMM;
        end
        ADDIU_EXEC: begin
          alu_srca_sel = SRCA_RS;
          alu_srcb_sel = SRCB_IMM;
          alu_op       = ALUOP_ADDU;
        end
        ALU_RI_WB: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          illegal_op = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multcyc_ctrl_fsm.sv
// Directed bench for multcyc_ctrl_fsm: per-cycle expected output
// vectors are queued ahead of each instruction and popped at negedge.
module tb_multcyc_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [3:0] state;
  logic       mem_addr_sel;
  logic       alu_srca_sel;
  logic [1:0] alu_srcb_sel;
  logic [1:0] alu_op;
  logic       wreg_dst_sel;
  logic       wrbck_data_sel;
  logic [1:0] nxt_pc_sel;
  logic       ir_wr;
  logic       pc_wr;
  logic       pc_wr_cond;
  logic       mem_wr;
  logic       mem_rd;
  logic       reg_wr;
  logic       instr_done;
  logic       illegal_op;

  multcyc_ctrl_fsm dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .mem_ready(mem_ready),
    .state(state),
    .mem_addr_sel(mem_addr_sel),
    .alu_srca_sel(alu_srca_sel),
    .alu_srcb_sel(alu_srcb_sel),
    .alu_op(alu_op),
    .wreg_dst_sel(wreg_dst_sel),
    .wrbck_data_sel(wrbck_data_sel),
    .nxt_pc_sel(nxt_pc_sel),
    .ir_wr(ir_wr),
    .pc_wr(pc_wr),
    .pc_wr_cond(pc_wr_cond),
    .mem_wr(mem_wr),
    .mem_rd(mem_rd),
    .reg_wr(reg_wr),
    .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel = {addr,srca,srcb[1:0],aluop[1:0],wdst,wdata,npc[1:0]}
  localparam logic [9:0] S_DEF   = 10'b0_0_00_00_0_0_00;
  localparam logic [9:0] S_FETCH = 10'b0_0_01_00_0_0_00;
  localparam logic [9:0] S_DEC   = 10'b0_0_11_00_0_0_00;
  localparam logic [9:0] S_MADDR = 10'b0_1_10_00_0_0_00;
  localparam logic [9:0] S_MACC  = 10'b1_0_00_00_0_0_00;
  localparam logic [9:0] S_MWB   = 10'b0_0_00_00_0_1_00;
  localparam logic [9:0] S_RR    = 10'b0_1_00_10_0_0_00;
  localparam logic [9:0] S_RRWB  = 10'b0_0_00_00_1_0_00;
  localparam logic [9:0] S_BEQ   = 10'b0_1_00_01_0_0_01;
  localparam logic [9:0] S_JMP   = 10'b0_0_00_00_0_0_10;
  localparam logic [9:0] S_ADDIU = 10'b0_1_10_11_0_0_00;
  // strb = {ir_wr,pc_wr,pc_wr_cond,mem_wr,mem_rd,reg_wr,done,illegal}
  localparam logic [7:0] T_NONE  = 8'b0000_0000;
  localparam logic [7:0] T_F1    = 8'b1100_1000;
  localparam logic [7:0] T_F0    = 8'b0000_1000;
  localparam logic [7:0] T_ILL   = 8'b0000_0001;
  localparam logic [7:0] T_MRD   = 8'b0000_1000;
  localparam logic [7:0] T_WB    = 8'b0000_0110;
  localparam logic [7:0] T_MW0   = 8'b0001_0000;
  localparam logic [7:0] T_MW1   = 8'b0001_0010;
  localparam logic [7:0] T_BEQ   = 8'b0010_0010;
  localparam logic [7:0] T_JMP   = 8'b0100_0010;

  typedef struct {
    string      tag;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (instr_done === 1'b1) done_cnt++;

  function automatic logic [21:0] obs();
    return {state, mem_addr_sel, alu_srca_sel, alu_srcb_sel, alu_op,
            wreg_dst_sel, wrbck_data_sel, nxt_pc_sel,
            ir_wr, pc_wr, pc_wr_cond, mem_wr, mem_rd, reg_wr,
            instr_done, illegal_op};
  endfunction

  task automatic push(input string tag, input logic [3:0] st,
                      input logic [9:0] sel, input logic [7:0] strb);
    exp_t e;
    e.tag = tag;
    e.v   = {st, sel, strb};
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [21:0] o;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h required=entry", obs());
    end else begin
      e = q.pop_front();
      o = obs();
      assert (o === e.v) else begin
        fails++;
        $error("FAIL %s observed=%h required=%h", e.tag, o, e.v);
      end
    end
  endtask

  // Entry/exit point: 1 time unit after a rising edge.
  task automatic cyc(input logic mr);
    mem_ready = mr;
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h23;
    repeat (3) @(posedge clk);
    push("reset", 4'd0, S_DEF, T_NONE);
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LW: 5 cycles
    push("lw_fetch", 4'd0, S_FETCH, T_F1);
    push("lw_decode", 4'd1, S_DEC, T_NONE);
    push("lw_maddr", 4'd2, S_MADDR, T_NONE);
    push("lw_memrd", 4'd3, S_MACC, T_MRD);
    push("lw_wrbck", 4'd4, S_MWB, T_WB);
    repeat (5) cyc(1'b1);

    // SW with two stall cycles in MemWr
    opcode = 6'h2B;
    push("sw_fetch", 4'd0, S_FETCH, T_F1);
    push("sw_decode", 4'd1, S_DEC, T_NONE);
    push("sw_maddr", 4'd2, S_MADDR, T_NONE);
    push("sw_memwr_s0", 4'd5, S_MACC, T_MW0);
    push("sw_memwr_s1", 4'd5, S_MACC, T_MW0);
    push("sw_memwr_rdy", 4'd5, S_MACC, T_MW1);
    repeat (3) cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);

    // RR with a fetch stall; mem_ready low in RRExec is ignored
    opcode = 6'h00;
    push("rr_fetch_stall", 4'd0, S_FETCH, T_F0);
    push("rr_fetch", 4'd0, S_FETCH, T_F1);
    push("rr_decode", 4'd1, S_DEC, T_NONE);
    push("rr_exec", 4'd6, S_RR, T_NONE);
    push("rr_wrbck", 4'd7, S_RRWB, T_WB);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);

    // ADDIU
    opcode = 6'h09;
    push("addiu_fetch", 4'd0, S_FETCH, T_F1);
    push("addiu_decode", 4'd1, S_DEC, T_NONE);
    push("addiu_exec", 4'd11, S_ADDIU, T_NONE);
    push("addiu_wrbck", 4'd12, S_DEF, T_WB);
    repeat (4) cyc(1'b1);

    // BEQ
    opcode = 6'h04;
    push("beq_fetch", 4'd0, S_FETCH, T_F1);
    push("beq_decode", 4'd1, S_DEC, T_NONE);
    push("beq_exec", 4'd8, S_BEQ, T_BEQ);
    repeat (3) cyc(1'b1);

    // J
    opcode = 6'h02;
    push("j_fetch", 4'd0, S_FETCH, T_F1);
    push("j_decode", 4'd1, S_DEC, T_NONE);
    push("j_exec", 4'd9, S_JMP, T_JMP);
    repeat (3) cyc(1'b1);

    // Illegal opcode
    opcode = 6'h3F;
    push("ill_fetch", 4'd0, S_FETCH, T_F1);
    push("ill_decode", 4'd1, S_DEC, T_ILL);
    repeat (2) cyc(1'b1);

    // SW interrupted by async reset while stalled in MemWr
    opcode = 6'h2B;
    push("rst_sw_fetch", 4'd0, S_FETCH, T_F1);
    push("rst_sw_decode", 4'd1, S_DEC, T_NONE);
    push("rst_sw_maddr", 4'd2, S_MADDR, T_NONE);
    push("rst_sw_memwr", 4'd5, S_MACC, T_MW0);
    repeat (3) cyc(1'b1);
    cyc(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 4'd0, S_DEF, T_NONE);
    chk();
    @(posedge clk);
    #1;
    push("reset_hold", 4'd0, S_DEF, T_NONE);
    chk();
    rst_n = 1'b1;

    // Clean restart with J
    opcode = 6'h02;
    push("re_fetch", 4'd0, S_FETCH, T_F1);
    push("re_decode", 4'd1, S_DEC, T_NONE);
    push("re_jmp", 4'd9, S_JMP, T_JMP);
    push("re_next_fetch", 4'd0, S_FETCH, T_F1);
    repeat (4) cyc(1'b1);

    // LW, SW, RR, ADDIU, BEQ, J, J
    tests++;
    assert (done_cnt === 7) else begin
      fails++;
      $error("FAIL instr_done_count observed=%0d required=%0d", done_cnt, 7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multcyc_ctrl_fsm.md
Name: multcyc_ctrl_fsm

Overview:
- Main control state machine of the multicycle MIPS core; consumes the Opcodes, ALUops and MultcycCtrl package definitions.
- Sits between the instruction register (opcode source) and the datapath/memory (select and strobe sinks).
- Sequences Fetch/Decode/Execute/Memory/Writeback one state per cycle, stalling on memory.
- Reports instruction retirement and illegal opcodes.

Parameters:
- none; state and select encodings are fixed by MultcycCtrl::state_type and the select enums.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from the IR; valid from Decode onward
- mem_ready  in  1  memory access complete this cycle
- state  out  4  current state_type, debug
- mem_addr_sel  out  1  mem_addr_sel_t
- alu_srca_sel  out  1  alu_srca_sel_t
- alu_srcb_sel  out  2  alu_srcb_sel_t
- alu_op  out  2  ALUop_t
- wreg_dst_sel  out  1  wreg_dst_sel_t
- wrbck_data_sel  out  1  wrbck_data_sel_t
- nxt_pc_sel  out  2  nxt_pc_sel
- ir_wr, pc_wr, pc_wr_cond, mem_wr, mem_rd, reg_wr  out  1 each  datapath strobes
- instr_done  out  1  one-cycle pulse: instruction retires this cycle
- illegal_op  out  1  one-cycle pulse in Decode for an unsupported opcode

Behaviour:
- Moore outputs, combinational from state, plus mem_ready gating where stated.
- Defaults in every state unless overridden:
  - selects: AddrPC, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout, PCPlus4
  - all strobes 0
- Reset: rst_n low forces state=Fetch asynchronously. While rst_n is low, all strobes and pulses are 0 and selects hold their defaults. Reset mid-instruction abandons it: no reg_wr or mem_wr.
- Fetch: mem_rd=1, SrcaPC, Four, ADD, PCPlus4.
  - ir_wr and pc_wr equal mem_ready.
  - Next state: Decode if mem_ready, else stay in Fetch.
- Decode: SrcaPC, BeqImm, ADD (branch target precompute). Next state by opcode:
  - RR -> RRExec
  - LW or SW -> MemAddr
  - BEQ (= BR) -> Beq
  - J -> Jmp
  - ADDI -> AddiExec
  - ADDIU -> AddiuExec
  - any other opcode -> Fetch, with illegal_op=1 for that cycle
- MemAddr: SrcaRs, SrcbImm, ADD. Next state: MemRd if opcode==LW, else MemWr.
- MemRd: AddrALUout, mem_rd=1. Next state: MemWrbck when mem_ready, else stay.
- MemWrbck: reg_wr=1, WrRt, MemData, instr_done=1. Next state: Fetch.
- MemWr: AddrALUout, mem_wr=1, held until mem_ready. instr_done=mem_ready. Next state: Fetch when mem_ready.
- RRExec: SrcaRs, SrcbRt, ALUop_RR. Next state: ALURRWrbck.
- ALURRWrbck: reg_wr=1, WrRd, ALUout, instr_done=1. Next state: Fetch.
- Beq: SrcaRs, SrcbRt, ALUop_SUB, pc_wr_cond=1, PCBranch, instr_done=1. Next state: Fetch. The datapath ANDs pc_wr_cond with the ALU zero flag.
- Jmp: pc_wr=1, PCJmp, instr_done=1. Next state: Fetch.
- AddiExec: SrcaRs, SrcbImm, ALUop_ADD. Next state: ALURIWrbck.
- AddiuExec: SrcaRs, SrcbImm, ALUop_ADDU. Next state: ALURIWrbck.
- ALURIWrbck: reg_wr=1, WrRt, ALUout, instr_done=1. Next state: Fetch.
- Unused encodings 13–15: all strobes 0, next state Fetch, no pulses.
- Latency with mem_ready held high:
  - LW: 5 cycles
  - SW, RR, ADDI, ADDIU: 4 cycles
  - BEQ, J: 3 cycles
- Each cycle of mem_ready low in Fetch, MemRd or MemWr adds one cycle.
- mem_ready is ignored in all other states.
- Exactly one instr_done pulse per retired instruction; none for illegal opcodes.

Test Plan:
- Reset low 3 cycles, release, mem_ready=1, opcode=6'h23 (LW) -> states Fetch,Decode,MemAddr,MemRd,MemWrbck; reg_wr=1 with WrRt/MemData in cycle 5; instr_done pulses once.
- SW (6'h2B) with mem_ready low for 2 cycles in MemWr -> mem_wr high 3 cycles with AddrALUout; Fetch after the ready cycle; no reg_wr.
- RR (6'h00), then ADDIU (6'h09) -> ALUop_RR with WrRd; then ALUop_ADDU with SrcbImm and WrRt; 4 cycles each.
- BEQ (6'h04), then J (6'h02) -> Beq drives SUB, pc_wr_cond=1, PCBranch; Jmp drives pc_wr=1, PCJmp; 3 cycles each.
- Opcode 6'h3F at Decode -> illegal_op pulse, next state Fetch, no reg_wr/mem_wr/instr_done.
- rst_n asserted asynchronously mid-MemWr -> mem_wr drops immediately; state=Fetch; restart fetches cleanly.
